// File: rtl/conv_accum_g3.sv
// conv_accum_g3: self-sequencing 3x3 kernel accumulator over a 4x4 pixel window.
// Produces a 2x2 block of kernel results (ul, ur, ll, lr) per lane from 16
// row-major pixel beats; NUM_CH lanes share one valid/ready handshake.
// Modes: 00 gaussian, 01 sobel-y, 10 sobel-x, 11 reserved (all-zero weights).
// Optional feature macro: POST_PROC_EN (normalised gaussian / |sobel| outputs).
// Ports:
//   i_clk, i_rst_n       clock, synchronous active-low reset
//   i_clear              synchronous abort of the current window / pending result
//   i_mode               kernel select, latched on pixel 0 of a window
//   i_in_valid/o_in_ready pixel beat handshake, i_pix lane n at [n*DATA_WIDTH +: DATA_WIDTH]
//   o_out_valid/i_out_ready result handshake, o_acc lane n pos p at [(4n+p)*ACC_W +: ACC_W]
//   o_busy               high while accumulating or holding a result
module conv_accum_g3 #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_CH     = 1,
  localparam int unsigned ACC_W     = DATA_WIDTH + 5
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_clear,
  input  logic [1:0]                     i_mode,
  input  logic                           i_in_valid,
  output logic                           o_in_ready,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   i_pix,
  output logic                           o_out_valid,
  input  logic                           i_out_ready,
  output logic [NUM_CH*4*ACC_W-1:0]      o_acc,
  output logic                           o_busy
);

  localparam int unsigned ACC_BITS = NUM_CH * 4 * ACC_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            k_q, k_d;
  logic [1:0]            mode_q, mode_d;
  logic [ACC_BITS-1:0]   acc_q, acc_d;

  logic                  accept_c;
  logic                  load_c;
  logic                  add_c;
  logic [1:0]            mode_sel_c;
  logic [3:0]            k_sel_c;

  // Signed contribution of one pixel (index k) to output position pos.
  // Weights are built from shifts and negations of the zero-extended pixel.
  function automatic logic [ACC_W-1:0] contrib(
    input logic [DATA_WIDTH-1:0] pix,
    input logic [3:0]            k,
    input logic [1:0]            pos,
    input logic [1:0]            mode
  );
    logic [1:0]       r, c, dr, dc, sh;
    logic             in_win;
    logic [ACC_W-1:0] px, mag, res;
    r      = k[3:2];
    c      = k[1:0];
    dr     = r - {1'b0, pos[1]};
    dc     = c - {1'b0, pos[0]};
    // Offset 3 (wrapped) or negative offsets fall outside the 3x3 kernel.
    in_win = (r >= {1'b0, pos[1]}) && (dr != 2'd3) &&
             (c >= {1'b0, pos[0]}) && (dc != 2'd3);
    px     = ACC_W'(pix);
    mag    = '0;
    res    = '0;
    sh     = {1'b0, dr == 2'd1} + {1'b0, dc == 2'd1};
    case (mode)
      2'b00: res = px << sh;
      2'b01: begin
        mag = (dc == 2'd1) ? (px << 1) : px;
        if (dr == 2'd0)      res = -mag;
        else if (dr == 2'd2) res = mag;
      end
      2'b10: begin
        mag = (dr == 2'd1) ? (px << 1) : px;
        if (dc == 2'd0)      res = -mag;
        else if (dc == 2'd2) res = mag;
      end
      default: res = '0;
    endcase
    if (!in_win) res = '0;
    return res;
  endfunction

  // Input ready passes i_out_ready straight through so a held result and the
  // next window's pixel 0 can be exchanged in the same cycle.
  assign o_in_ready  = (state_q != S_HOLD) | i_out_ready;
  assign accept_c    = i_in_valid & o_in_ready;
  assign o_out_valid = (state_q == S_HOLD);
  assign o_busy      = (state_q != S_IDLE);

  // Next-state, counter, mode latch and accumulator update.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    mode_d     = mode_q;
    acc_d      = acc_q;
    load_c     = 1'b0;
    add_c      = 1'b0;
    mode_sel_c = mode_q;
    k_sel_c    = k_q;

    if (i_clear) begin
      state_d = S_IDLE;
      k_d     = 4'd0;
      acc_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_c) load_c = 1'b1;
        end
        S_ACCUM: begin
          if (accept_c) begin
            add_c = 1'b1;
            k_d   = k_q + 4'd1;
            if (k_q == 4'd15) state_d = S_HOLD;
          end
        end
        S_HOLD: begin
          if (i_out_ready) begin
            state_d = S_IDLE;
            k_d     = 4'd0;
            if (accept_c) load_c = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          k_d     = 4'd0;
        end
      endcase

      // Pixel 0 of a window overwrites the accumulators and latches the mode.
      if (load_c) begin
        state_d    = S_ACCUM;
        k_d        = 4'd1;
        mode_d     = i_mode;
        mode_sel_c = i_mode;
        k_sel_c    = 4'd0;
      end

      for (int unsigned n = 0; n < NUM_CH; n++) begin
        for (int unsigned p = 0; p < 4; p++) begin
          if (load_c) begin
            acc_d[(4*n+p)*ACC_W +: ACC_W] =
              contrib(i_pix[n*DATA_WIDTH +: DATA_WIDTH], k_sel_c, 2'(p), mode_sel_c);
          end else if (add_c) begin
            acc_d[(4*n+p)*ACC_W +: ACC_W] = acc_q[(4*n+p)*ACC_W +: ACC_W] +
              contrib(i_pix[n*DATA_WIDTH +: DATA_WIDTH], k_sel_c, 2'(p), mode_sel_c);
          end
        end
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      k_q     <= 4'd0;
      mode_q  <= 2'b00;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      mode_q  <= mode_d;
      acc_q   <= acc_d;
    end
  end

`ifdef POST_PROC_EN
  // Normalised view of the sums: rounded /16 for gaussian, magnitude for sobel.
  always_comb begin
    o_acc = '0;
    for (int unsigned i = 0; i < NUM_CH * 4; i++) begin
      case (mode_q)
        2'b00: o_acc[i*ACC_W +: ACC_W] = (acc_q[i*ACC_W +: ACC_W] + ACC_W'(8)) >> 4;
        2'b01, 2'b10: o_acc[i*ACC_W +: ACC_W] = acc_q[i*ACC_W + ACC_W - 1] ?
                                                -acc_q[i*ACC_W +: ACC_W] :
                                                acc_q[i*ACC_W +: ACC_W];
        default: o_acc[i*ACC_W +: ACC_W] = '0;
      endcase
    end
  end
`else
  assign o_acc = acc_q;
`endif

endmodule
